rename_init_sequencer: RTL and testbench
========================================

Name: rename_init_sequencer

Overview:
- Sequences initialisation of the register-renaming datapath: the speculative rd-to-phys tables (GP and optional FP) and the physical-register free lists.
- After reset, or on a software/global-control reinit request, it drains in-flight renamed writes. It then clears the free lists and walks every architectural index, writing identity mappings into the tables and pushing the non-architectural physical registers into the free lists.
- It holds decode for the whole sequence and releases it when the datapath is consistent.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers per file; each gets an identity mapping.
- NUM_PHYS_REGS, 64, physical registers per file; must be greater than NUM_ARCH_REGS.
- INCLUDE_FP, 1, also drive the FP table and FP free list; when 0, FP outputs are tied to 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- reinit_req  in  1  single-cycle request to reinitialise the rename state
- inflight_empty  in  1  in-use list empty (no renamed write awaiting retire)
- busy  out  1  sequence active; gates decode_advance upstream
- done  out  1  one-cycle pulse on the last CLEAR cycle
- free_list_clear  out  1  one-cycle pulse that resets free-list pointers/counts
- table_we  out  1  GP spec-table write enable
- fp_table_we  out  1  FP spec-table write enable
- table_waddr  out  $clog2(NUM_ARCH_REGS)  table write index
- table_wdata  out  $clog2(NUM_PHYS_REGS)  physical address written (equals index); wb_group written as 0 by the table owner
- free_push  out  1  GP free-list push
- fp_free_push  out  1  FP free-list push
- free_data  out  $clog2(NUM_PHYS_REGS)  physical address pushed, NUM_ARCH_REGS + index

Behaviour:
- Walk length and counter:
  - W = max(NUM_ARCH_REGS, NUM_PHYS_REGS - NUM_ARCH_REGS); W = 32 with the defaults.
  - idx is a binary counter of $clog2(W) bits (min 1).
- States: PRE, CLEAR, RUN, DRAIN. All state and idx are async-reset: state = PRE, idx = 0.
- PRE, one cycle:
  - busy = 1, free_list_clear = 1.
  - All write/push enables = 0, done = 0.
  - Next state CLEAR with idx = 0.
  - While rst is asserted, the outputs are the PRE values.
- CLEAR:
  - busy = 1.
  - table_we = (idx < NUM_ARCH_REGS); fp_table_we = table_we & INCLUDE_FP.
  - table_waddr = idx[$clog2(NUM_ARCH_REGS)-1:0]; table_wdata = idx zero-extended.
  - free_push = (idx < NUM_PHYS_REGS - NUM_ARCH_REGS); fp_free_push = free_push & INCLUDE_FP.
  - free_data = NUM_ARCH_REGS + idx.
  - idx increments each cycle. On idx == W-1: done = 1, next state RUN, idx returns to 0.
- Timing: with the defaults, first table write is cycle 1 after reset deassertion; last write and done are at cycle 32; busy falls at cycle 33.
- RUN:
  - busy = 0; all enables, free_list_clear and done = 0.
  - reinit_req = 1 -> DRAIN.
- DRAIN:
  - busy = 1, no writes.
  - Stays in DRAIN while inflight_empty = 0.
  - inflight_empty = 1 -> PRE on the next cycle, even if it is high in the first DRAIN cycle. Minimum RUN-to-PRE is 2 cycles.
- reinit_req in PRE, CLEAR or DRAIN is ignored: no restart, no queuing.
- reinit_req and inflight_empty are sampled only in RUN and DRAIN respectively.
- Reset asserted in any state aborts immediately to PRE, idx = 0. The next CLEAR restarts at idx 0, and free_list_clear pulses again, so a partially filled free list is discarded.
- Output timing: outputs are combinational from state/idx only, with no input-to-output combinational path except through state.
- Exactly one write per table index and one push per free register per CLEAR pass. There are no duplicate or skipped indices at wrap.
- Unequal sizes, e.g. 32/48: table writes for idx 0..31, pushes for idx 0..15. W = 32, so pushes stop early.

Test Plan:
- Reset release, defaults -> cycle 1 free_list_clear = 0, table_we = 1 with waddr 0, wdata 0, free_data 32; cycle 32 waddr 31, free_data 63, done = 1; cycle 33 busy = 0. Exactly 32 table writes and 32 pushes.
- INCLUDE_FP = 0 -> fp_table_we and fp_free_push stay 0 throughout CLEAR; GP writes are unchanged.
- RUN, reinit_req pulse with inflight_empty = 0 for 10 cycles then 1 -> busy = 1 throughout, no writes during DRAIN, PRE one cycle later with free_list_clear = 1, then a full 32-cycle CLEAR.
- reinit_req pulsed at CLEAR idx = 5 and again in DRAIN -> no restart or extension; done still at idx 31; after the reinit-triggered CLEAR the block stays in RUN.
- rst asserted at CLEAR idx = 20 -> enables drop asynchronously; after release PRE, then writes resume from idx 0 with 32 writes total after release.
- NUM_PHYS_REGS = 48 -> free pushes only for data 32..47 (idx 0..15); table writes 0..31; done at idx 31.

Source files
------------

// File: rtl/rename_init_sequencer.sv
// Purpose: holds decode while the rename tables get identity maps and the free lists are refilled.
// Latency: one PRE cycle, then a W-cycle CLEAR walk; done pulses on the last walk cycle.
// Backpressure: reinit waits in DRAIN until inflight_empty; reinit_req is ignored outside RUN.
module rename_init_sequencer #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  parameter int INCLUDE_FP    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             reinit_req,
  input  logic                             inflight_empty,
  output logic                             busy,
  output logic                             done,
  output logic                             free_list_clear,
  output logic                             table_we,
  output logic                             fp_table_we,
  output logic [$clog2(NUM_ARCH_REGS)-1:0] table_waddr,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] table_wdata,
  output logic                             free_push,
  output logic                             fp_free_push,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] free_data
);

  localparam int NUM_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int W        = (NUM_ARCH_REGS > NUM_FREE) ? NUM_ARCH_REGS : NUM_FREE;
  localparam int IW       = (W > 1) ? $clog2(W) : 1;
  localparam int AW       = $clog2(NUM_ARCH_REGS);
  localparam int PW       = $clog2(NUM_PHYS_REGS);

  // One extra bit so a limit equal to 2**IW still compares correctly.
  localparam logic [IW:0]   ARCH_LIM  = (IW+1)'(NUM_ARCH_REGS);
  localparam logic [IW:0]   FREE_LIM  = (IW+1)'(NUM_FREE);
  localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);
  localparam logic [PW-1:0] FREE_BASE = PW'(NUM_ARCH_REGS);
  localparam logic          FP_EN     = (INCLUDE_FP != 0);

  typedef enum logic [1:0] {PRE, CLEAR, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          in_arch, in_free;

  assign in_arch = ({1'b0, idx} < ARCH_LIM);
  assign in_free = ({1'b0, idx} < FREE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PRE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Outputs depend on state/idx only; inputs reach outputs solely via the state register.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    busy            = 1'b1;
    done            = 1'b0;
    free_list_clear = 1'b0;
    table_we        = 1'b0;
    fp_table_we     = 1'b0;
    free_push       = 1'b0;
    fp_free_push    = 1'b0;
    table_waddr     = idx[AW-1:0];
    table_wdata     = PW'(idx);
    free_data       = FREE_BASE + PW'(idx);

    case (state)
      PRE: begin
        free_list_clear = 1'b1;
        state_nxt       = CLEAR;
        idx_nxt         = '0;
      end
      CLEAR: begin
        table_we     = in_arch;
        fp_table_we  = in_arch & FP_EN;
        free_push    = in_free;
        fp_free_push = in_free & FP_EN;
        if (idx == LAST_IDX) begin
          done      = 1'b1;
          state_nxt = RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      RUN: begin
        busy = 1'b0;
        if (reinit_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight_empty) state_nxt = PRE;
      end
      default: state_nxt = PRE;
    endcase
  end

endmodule

// File: tb/tb_rename_init_sequencer.sv
// Bench for rename_init_sequencer: default, FP-less and 32/48 instances share stimulus;
// a negedge monitor logs writes/pushes and each scenario checks them against expected queues.
module tb_rename_init_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reinit_req = 1'b0;
  logic inflight_empty = 1'b1;

  logic       d_busy, d_done, d_flc, d_twe, d_fptwe, d_fpush, d_fpfpush;
  logic [4:0] d_waddr;
  logic [5:0] d_wdata, d_fdata;
  logic       n_busy, n_done, n_flc, n_twe, n_fptwe, n_fpush, n_fpfpush;
  logic [4:0] n_waddr;
  logic [5:0] n_wdata, n_fdata;
  logic       p_busy, p_done, p_flc, p_twe, p_fptwe, p_fpush, p_fpfpush;
  logic [4:0] p_waddr;
  logic [5:0] p_wdata, p_fdata;

  int checks   = 0;
  int failures = 0;

  // table record {we, fp_we, waddr, wdata}; free record {push, fp_push, data}
  logic [12:0] d_tw[$], n_tw[$], p_tw[$], exp_d_tw[$], exp_n_tw[$], exp_p_tw[$];
  logic [7:0]  d_fl[$], n_fl[$], p_fl[$], exp_d_fl[$], exp_n_fl[$], exp_p_fl[$];

  always #5 clk = ~clk;

  rename_init_sequencer u_dut (
    .clk(clk), .rst(rst), .reinit_req(reinit_req), .inflight_empty(inflight_empty),
    .busy(d_busy), .done(d_done), .free_list_clear(d_flc), .table_we(d_twe),
    .fp_table_we(d_fptwe), .table_waddr(d_waddr), .table_wdata(d_wdata),
    .free_push(d_fpush), .fp_free_push(d_fpfpush), .free_data(d_fdata));

  rename_init_sequencer #(.INCLUDE_FP(0)) u_nofp (
    .clk(clk), .rst(rst), .reinit_req(reinit_req), .inflight_empty(inflight_empty),
    .busy(n_busy), .done(n_done), .free_list_clear(n_flc), .table_we(n_twe),
    .fp_table_we(n_fptwe), .table_waddr(n_waddr), .table_wdata(n_wdata),
    .free_push(n_fpush), .fp_free_push(n_fpfpush), .free_data(n_fdata));

  rename_init_sequencer #(.NUM_PHYS_REGS(48)) u_p48 (
    .clk(clk), .rst(rst), .reinit_req(reinit_req), .inflight_empty(inflight_empty),
    .busy(p_busy), .done(p_done), .free_list_clear(p_flc), .table_we(p_twe),
    .fp_table_we(p_fptwe), .table_waddr(p_waddr), .table_wdata(p_wdata),
    .free_push(p_fpush), .fp_free_push(p_fpfpush), .free_data(p_fdata));

  always @(negedge clk) begin
    if (d_twe | d_fptwe)     d_tw.push_back({d_twe, d_fptwe, d_waddr, d_wdata});
    if (d_fpush | d_fpfpush) d_fl.push_back({d_fpush, d_fpfpush, d_fdata});
    if (n_twe | n_fptwe)     n_tw.push_back({n_twe, n_fptwe, n_waddr, n_wdata});
    if (n_fpush | n_fpfpush) n_fl.push_back({n_fpush, n_fpfpush, n_fdata});
    if (p_twe | p_fptwe)     p_tw.push_back({p_twe, p_fptwe, p_waddr, p_wdata});
    if (p_fpush | p_fpfpush) p_fl.push_back({p_fpush, p_fpfpush, p_fdata});
  end

  task automatic clear_queues();
    d_tw.delete(); n_tw.delete(); p_tw.delete();
    d_fl.delete(); n_fl.delete(); p_fl.delete();
    exp_d_tw.delete(); exp_n_tw.delete(); exp_p_tw.delete();
    exp_d_fl.delete(); exp_n_fl.delete(); exp_p_fl.delete();
  endtask

  // Expected writes/pushes for the first n indices of a CLEAR walk, per instance.
  task automatic expect_clear(input int n);
    for (int i = 0; i < n; i++) begin
      exp_d_tw.push_back({1'b1, 1'b1, 5'(i), 6'(i)});
      exp_d_fl.push_back({1'b1, 1'b1, 6'(32 + i)});
      exp_n_tw.push_back({1'b1, 1'b0, 5'(i), 6'(i)});
      exp_n_fl.push_back({1'b1, 1'b0, 6'(32 + i)});
      exp_p_tw.push_back({1'b1, 1'b1, 5'(i), 6'(i)});
      if (i < 16) exp_p_fl.push_back({1'b1, 1'b1, 6'(32 + i)});
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    clear_queues();
    expect_clear(32);
    rst = 1'b0;
  endtask

  task automatic test_reset_release();
    logic [12:0] o13, e13;
    logic [7:0]  o8, e8;
    @(negedge clk);
    checks++;
    if ({d_busy, d_flc, d_twe, d_fpush, d_done} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_state got busy,flc,twe,push,done=%b exp 11000",
               {d_busy, d_flc, d_twe, d_fpush, d_done});
    end
    clear_queues();
    expect_clear(32);
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if ({d_flc, d_twe, d_waddr, d_wdata, d_fdata} !== {1'b0, 1'b1, 5'd0, 6'd0, 6'd32}) begin
          failures++;
          $display("FAIL first_write got flc=%b we=%b a=%0d d=%0d f=%0d exp 0 1 0 0 32",
                   d_flc, d_twe, d_waddr, d_wdata, d_fdata);
        end
      end
      if (k == 31 || k == 32) begin
        checks++;
        if (d_done !== (k == 32)) begin
          failures++;
          $display("FAIL done_timing cycle=%0d got=%b exp=%b", k, d_done, (k == 32));
        end
      end
      if (k == 32) begin
        checks++;
        if ({d_waddr, d_fdata} !== {5'd31, 6'd63}) begin
          failures++;
          $display("FAIL last_write got a=%0d f=%0d exp 31 63", d_waddr, d_fdata);
        end
      end
      if (k == 33) begin
        checks++;
        if (d_busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_release got=%b exp=0", d_busy);
        end
      end
    end
    while (d_tw.size() > 0 && exp_d_tw.size() > 0) begin
      o13 = d_tw.pop_front(); e13 = exp_d_tw.pop_front(); checks++;
      if (o13 !== e13) begin failures++; $display("FAIL reset_tw got=%h exp=%h", o13, e13); end
    end
    checks++;
    if (d_tw.size() + exp_d_tw.size() != 0) begin
      failures++; $display("FAIL reset_tw_count obs_left=%0d exp_left=%0d", d_tw.size(), exp_d_tw.size());
    end
    while (d_fl.size() > 0 && exp_d_fl.size() > 0) begin
      o8 = d_fl.pop_front(); e8 = exp_d_fl.pop_front(); checks++;
      if (o8 !== e8) begin failures++; $display("FAIL reset_fl got=%h exp=%h", o8, e8); end
    end
    checks++;
    if (d_fl.size() + exp_d_fl.size() != 0) begin
      failures++; $display("FAIL reset_fl_count obs_left=%0d exp_left=%0d", d_fl.size(), exp_d_fl.size());
    end
  endtask

  task automatic test_no_fp();
    logic [12:0] o13, e13;
    logic [7:0]  o8, e8;
    pulse_reset();
    repeat (34) @(negedge clk);
    while (n_tw.size() > 0 && exp_n_tw.size() > 0) begin
      o13 = n_tw.pop_front(); e13 = exp_n_tw.pop_front(); checks++;
      if (o13 !== e13) begin failures++; $display("FAIL nofp_tw got=%h exp=%h", o13, e13); end
    end
    checks++;
    if (n_tw.size() + exp_n_tw.size() != 0) begin
      failures++; $display("FAIL nofp_tw_count obs_left=%0d exp_left=%0d", n_tw.size(), exp_n_tw.size());
    end
    while (n_fl.size() > 0 && exp_n_fl.size() > 0) begin
      o8 = n_fl.pop_front(); e8 = exp_n_fl.pop_front(); checks++;
      if (o8 !== e8) begin failures++; $display("FAIL nofp_fl got=%h exp=%h", o8, e8); end
    end
    checks++;
    if (n_fl.size() + exp_n_fl.size() != 0) begin
      failures++; $display("FAIL nofp_fl_count obs_left=%0d exp_left=%0d", n_fl.size(), exp_n_fl.size());
    end
  endtask

  task automatic test_phys48();
    logic [12:0] o13, e13;
    logic [7:0]  o8, e8;
    pulse_reset();
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 32) begin
        checks++;
        if ({p_done, p_waddr} !== {1'b1, 5'd31}) begin
          failures++; $display("FAIL p48_done got done=%b a=%0d exp 1 31", p_done, p_waddr);
        end
      end
    end
    while (p_tw.size() > 0 && exp_p_tw.size() > 0) begin
      o13 = p_tw.pop_front(); e13 = exp_p_tw.pop_front(); checks++;
      if (o13 !== e13) begin failures++; $display("FAIL p48_tw got=%h exp=%h", o13, e13); end
    end
    checks++;
    if (p_tw.size() + exp_p_tw.size() != 0) begin
      failures++; $display("FAIL p48_tw_count obs_left=%0d exp_left=%0d", p_tw.size(), exp_p_tw.size());
    end
    while (p_fl.size() > 0 && exp_p_fl.size() > 0) begin
      o8 = p_fl.pop_front(); e8 = exp_p_fl.pop_front(); checks++;
      if (o8 !== e8) begin failures++; $display("FAIL p48_fl got=%h exp=%h", o8, e8); end
    end
    checks++;
    if (p_fl.size() + exp_p_fl.size() != 0) begin
      failures++; $display("FAIL p48_fl_count obs_left=%0d exp_left=%0d", p_fl.size(), exp_p_fl.size());
    end
  endtask

  task automatic test_reinit_drain();
    logic [12:0] o13, e13;
    logic [7:0]  o8, e8;
    @(negedge clk);
    clear_queues();
    inflight_empty = 1'b0;
    reinit_req     = 1'b1;
    @(negedge clk);
    reinit_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({d_busy, d_flc, d_twe, d_fpush, d_done} !== 5'b10000) begin
        failures++;
        $display("FAIL drain_hold cycle=%0d got busy,flc,twe,push,done=%b exp 10000", i,
                 {d_busy, d_flc, d_twe, d_fpush, d_done});
      end
      @(negedge clk);
    end
    inflight_empty = 1'b1;
    expect_clear(32);
    @(negedge clk);
    checks++;
    if ({d_busy, d_flc, d_twe} !== 3'b110) begin
      failures++; $display("FAIL drain_pre got busy,flc,twe=%b exp 110", {d_busy, d_flc, d_twe});
    end
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 32 || k == 33) begin
        checks++;
        if ({d_done, d_busy} !== ((k == 32) ? 2'b11 : 2'b00)) begin
          failures++; $display("FAIL drain_clear_end cycle=%0d got done,busy=%b", k, {d_done, d_busy});
        end
      end
    end
    while (d_tw.size() > 0 && exp_d_tw.size() > 0) begin
      o13 = d_tw.pop_front(); e13 = exp_d_tw.pop_front(); checks++;
      if (o13 !== e13) begin failures++; $display("FAIL drain_tw got=%h exp=%h", o13, e13); end
    end
    checks++;
    if (d_tw.size() + exp_d_tw.size() != 0) begin
      failures++; $display("FAIL drain_tw_count obs_left=%0d exp_left=%0d", d_tw.size(), exp_d_tw.size());
    end
    while (d_fl.size() > 0 && exp_d_fl.size() > 0) begin
      o8 = d_fl.pop_front(); e8 = exp_d_fl.pop_front(); checks++;
      if (o8 !== e8) begin failures++; $display("FAIL drain_fl got=%h exp=%h", o8, e8); end
    end
    checks++;
    if (d_fl.size() + exp_d_fl.size() != 0) begin
      failures++; $display("FAIL drain_fl_count obs_left=%0d exp_left=%0d", d_fl.size(), exp_d_fl.size());
    end
  endtask

  task automatic test_reinit_ignored();
    logic [12:0] o13, e13;
    int done_cnt = 0;
    @(negedge clk);
    clear_queues();
    inflight_empty = 1'b0;
    reinit_req     = 1'b1;
    @(negedge clk);
    reinit_req = 1'b0;
    @(negedge clk);
    reinit_req = 1'b1;
    @(negedge clk);
    reinit_req     = 1'b0;
    inflight_empty = 1'b1;
    expect_clear(32);
    @(negedge clk);
    checks++;
    if (d_flc !== 1'b1) begin failures++; $display("FAIL ign_pre got flc=%b exp=1", d_flc); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      reinit_req = (k == 6);
      if (d_done) done_cnt++;
      if (k == 6) begin
        checks++;
        if (d_waddr !== 5'd5) begin failures++; $display("FAIL ign_idx5 got=%0d exp=5", d_waddr); end
      end
      if (k == 32) begin
        checks++;
        if ({d_done, d_waddr} !== {1'b1, 5'd31}) begin
          failures++; $display("FAIL ign_done got done=%b a=%0d exp 1 31", d_done, d_waddr);
        end
      end
      if (k > 32) begin
        checks++;
        if (d_busy !== 1'b0) begin failures++; $display("FAIL ign_run cycle=%0d busy=%b exp=0", k, d_busy); end
      end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
    while (d_tw.size() > 0 && exp_d_tw.size() > 0) begin
      o13 = d_tw.pop_front(); e13 = exp_d_tw.pop_front(); checks++;
      if (o13 !== e13) begin failures++; $display("FAIL ign_tw got=%h exp=%h", o13, e13); end
    end
    checks++;
    if (d_tw.size() + exp_d_tw.size() != 0) begin
      failures++; $display("FAIL ign_tw_count obs_left=%0d exp_left=%0d", d_tw.size(), exp_d_tw.size());
    end
  endtask

  task automatic test_rst_midclear();
    logic [12:0] o13, e13;
    logic [7:0]  o8, e8;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    clear_queues();
    expect_clear(21);
    rst = 1'b0;
    repeat (21) @(negedge clk);
    checks++;
    if ({d_twe, d_waddr} !== {1'b1, 5'd20}) begin
      failures++; $display("FAIL mid_idx20 got we=%b a=%0d exp 1 20", d_twe, d_waddr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({d_busy, d_flc, d_twe, d_fpush, d_done} !== 5'b11000) begin
      failures++;
      $display("FAIL mid_abort got busy,flc,twe,push,done=%b exp 11000", {d_busy, d_flc, d_twe, d_fpush, d_done});
    end
    expect_clear(32);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if ({d_twe, d_waddr, d_fdata} !== {1'b1, 5'd0, 6'd32}) begin
          failures++; $display("FAIL mid_restart got we=%b a=%0d f=%0d exp 1 0 32", d_twe, d_waddr, d_fdata);
        end
      end
      if (k == 33) begin
        checks++;
        if (d_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", d_busy); end
      end
    end
    while (d_tw.size() > 0 && exp_d_tw.size() > 0) begin
      o13 = d_tw.pop_front(); e13 = exp_d_tw.pop_front(); checks++;
      if (o13 !== e13) begin failures++; $display("FAIL mid_tw got=%h exp=%h", o13, e13); end
    end
    checks++;
    if (d_tw.size() + exp_d_tw.size() != 0) begin
      failures++; $display("FAIL mid_tw_count obs_left=%0d exp_left=%0d", d_tw.size(), exp_d_tw.size());
    end
    while (d_fl.size() > 0 && exp_d_fl.size() > 0) begin
      o8 = d_fl.pop_front(); e8 = exp_d_fl.pop_front(); checks++;
      if (o8 !== e8) begin failures++; $display("FAIL mid_fl got=%h exp=%h", o8, e8); end
    end
    checks++;
    if (d_fl.size() + exp_d_fl.size() != 0) begin
      failures++; $display("FAIL mid_fl_count obs_left=%0d exp_left=%0d", d_fl.size(), exp_d_fl.size());
    end
  endtask

  initial begin
    test_reset_release();
    test_no_fp();
    test_phys48();
    test_reinit_drain();
    test_reinit_ignored();
    test_rst_midclear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
